// File: rtl/te_pkg.sv
// te_pkg: shared pixel/window types and defaults for the TE path.
package te_pkg;
  localparam int DATA_W     = 8;
  localparam int IMG_W_DFLT = 512;
  localparam int IMG_H_DFLT = 512;

  typedef logic [DATA_W-1:0] pix_t;
  // in1..in9 row-major, index 0 = top-left
  typedef pix_t [8:0] win_t;
endpackage

// File: rtl/te_line_buffer.sv
// te_line_buffer: one-row circular pixel store.
// Read-before-write at the same address.
module te_line_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 512,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign rd_data = mem_q[addr];

  always_ff @(posedge clk) begin
    if (en) mem_q[addr] <= wr_data;
  end
endmodule

// File: rtl/te_window_3x3.sv
// te_window_3x3: streaming 3x3 window generator for the TE filters.
// Optional frame_done output under TE_WINDOW_FRAME_DONE_EN.
module te_window_3x3
  import te_pkg::*;
#(
  parameter int DATA_W = te_pkg::DATA_W,
  parameter int IMG_W  = IMG_W_DFLT,
  parameter int IMG_H  = IMG_H_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_pixel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic [DATA_W-1:0] out4,
  output logic [DATA_W-1:0] out5,
  output logic [DATA_W-1:0] out6,
  output logic [DATA_W-1:0] out7,
  output logic [DATA_W-1:0] out8,
`ifdef TE_WINDOW_FRAME_DONE_EN
  output logic [DATA_W-1:0] out9,
  output logic              frame_done
`else
  output logic [DATA_W-1:0] out9
`endif
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [8:0][DATA_W-1:0] win_q, win_d;
  logic vld_q, vld_d;
  logic [DATA_W-1:0] t1, t2;

  te_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
    .clk     (clk),
    .en      (in_valid),
    .addr    (col_q),
    .wr_data (in_pixel),
    .rd_data (t1)
  );

  te_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb2 (
    .clk     (clk),
    .en      (in_valid),
    .addr    (col_q),
    .wr_data (t1),
    .rd_data (t2)
  );

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    win_d = win_q;
    vld_d = 1'b0;
    if (in_valid) begin
      vld_d = (row_q >= RW'(2)) && (col_q >= CW'(2));
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = t2;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = t1;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = in_pixel;
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      win_q <= '0;
      vld_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      win_q <= win_d;
      vld_q <= vld_d;
    end
  end

`ifdef TE_WINDOW_FRAME_DONE_EN
  logic fd_q, fd_d;

  assign fd_d = in_valid && (row_q == ROW_LAST)
             && (col_q == COL_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fd_q <= 1'b0;
    else     fd_q <= fd_d;
  end

  assign frame_done = fd_q;
`endif

  assign out_valid = vld_q;
  assign out1 = win_q[0];
  assign out2 = win_q[1];
  assign out3 = win_q[2];
  assign out4 = win_q[3];
  assign out5 = win_q[4];
  assign out6 = win_q[5];
  assign out7 = win_q[6];
  assign out8 = win_q[7];
  assign out9 = win_q[8];
endmodule

// File: tb/tb_te_window_3x3.sv
// tb_te_window_3x3: directed bench for te_window_3x3 (5x4 image).
// Also checks frame_done when TE_WINDOW_FRAME_DONE_EN is defined.
module tb_te_window_3x3;
  localparam int W = 5;
  localparam int H = 4;

  typedef struct {
    logic [71:0] w;
    logic        fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [7:0] in_pixel = '0;
  logic out_valid;
  logic [7:0] out1, out2, out3, out4, out5;
  logic [7:0] out6, out7, out8, out9;
  logic frame_done;

  int n_chk  = 0;
  int n_pass = 0;
  int fd_seen = 0;
  int fd_exp  = 0;
  logic prev_iv = 1'b0;
  exp_t exp_q[$];
  logic [71:0] seen[$];

  te_window_3x3 #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out4      (out4),
    .out5      (out5),
    .out6      (out6),
    .out7      (out7),
    .out8      (out8),
`ifdef TE_WINDOW_FRAME_DONE_EN
    .out9      (out9),
    .frame_done(frame_done)
`else
    .out9      (out9)
`endif
  );

`ifndef TE_WINDOW_FRAME_DONE_EN
  assign frame_done = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [71:0] got,
                       input logic [71:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [7:0] pix(input logic [7:0] base,
                                     input bit flat,
                                     input int r, input int c);
    return flat ? base : 8'(int'(base) + r * 16 + c);
  endfunction

  function automatic int mean9(input logic [71:0] w);
    int s = 0;
    for (int i = 0; i < 9; i++) s += int'(w[i*8 +: 8]);
    return (s * 57) >> 9;
  endfunction

  function automatic logic [71:0] cur_win();
    return {out1, out2, out3, out4, out5, out6, out7, out8, out9};
  endfunction

  always @(posedge clk) prev_iv <= in_valid;

  bit chk_mean = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (!prev_iv) check("stall_vld", {71'd0, out_valid}, 72'd0);
      if (frame_done) fd_seen++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_win", {71'd0, out_valid}, 72'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("win", cur_win(), e.w);
          seen.push_back(cur_win());
`ifdef TE_WINDOW_FRAME_DONE_EN
          check("fdone", {71'd0, frame_done}, {71'd0, e.fd});
`endif
          if (chk_mean)
            check("mean", 72'(mean9(cur_win())), 72'h90);
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] base, input bit flat,
                            input bit gaps, input int npix);
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++)
        if (r * W + c < npix) begin
          exp_t e;
          e.w = {pix(base, flat, r-2, c-2), pix(base, flat, r-2, c-1),
                 pix(base, flat, r-2, c),   pix(base, flat, r-1, c-2),
                 pix(base, flat, r-1, c-1), pix(base, flat, r-1, c),
                 pix(base, flat, r, c-2),   pix(base, flat, r, c-1),
                 pix(base, flat, r, c)};
          e.fd = (r == H-1) && (c == W-1) && (npix == W*H);
          exp_q.push_back(e);
        end
    if (npix == W*H) fd_exp++;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r * W + c < npix) begin
          if (gaps && $urandom_range(0, 1) == 1) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_pixel = 8'($urandom);
          end
          @(negedge clk);
          in_valid = 1'b1;
          in_pixel = pix(base, flat, r, c);
        end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #12;
    check("rst_vld", {71'd0, out_valid}, 72'd0);
    check("rst_win", cur_win(), 72'd0);
    check("rst_fd", {71'd0, frame_done}, 72'd0);
    @(negedge clk);
    rst = 1'b0;

    // continuous frame
    seen.delete();
    send_frame(8'h00, 1'b0, 1'b0, W*H);
    idle(3);
    check("f1_cnt", 72'(seen.size()), 72'd6);
    if (seen.size() > 0)
      check("f1_first", seen[0], 72'h00_01_02_10_11_12_20_21_22);
    check("f1_last_c", {64'd0, out5}, 72'h23);

    // random stalls
    seen.delete();
    send_frame(8'h00, 1'b0, 1'b1, W*H);
    idle(3);
    check("gap_cnt", 72'(seen.size()), 72'd6);
    check("gap_last_c", {64'd0, out5}, 72'h23);

    // back-to-back frames
    seen.delete();
    send_frame(8'h00, 1'b0, 1'b0, W*H);
    send_frame(8'h80, 1'b0, 1'b0, W*H);
    idle(3);
    check("b2b_cnt", 72'(seen.size()), 72'd12);
    if (seen.size() > 6)
      check("b2b_f2_c", {64'd0, seen[6][39:32]}, 72'h91);
    check("b2b_last_c", {64'd0, out5}, 72'hA3);

    // async reset after pixel 0x13
    seen.delete();
    send_frame(8'h00, 1'b0, 1'b0, 9);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mrst_vld", {71'd0, out_valid}, 72'd0);
    check("mrst_win", cur_win(), 72'd0);
    @(negedge clk);
    rst = 1'b0;
    send_frame(8'h40, 1'b0, 1'b0, W*H);
    idle(3);
    check("mrst_cnt", 72'(seen.size()), 72'd6);
    check("mrst_last_c", {64'd0, out5}, 72'h63);

    // flat frame into the mean filter
    seen.delete();
    chk_mean = 1'b1;
    send_frame(8'h90, 1'b1, 1'b0, W*H);
    idle(3);
    chk_mean = 1'b0;
    check("flat_cnt", 72'(seen.size()), 72'd6);

    check("q_empty", 72'(exp_q.size()), 72'd0);
`ifdef TE_WINDOW_FRAME_DONE_EN
    check("fd_cnt", 72'(fd_seen), 72'(fd_exp));
`else
    check("fd_none", 72'(fd_seen), 72'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
